// File: rtl/qos_weighted_scheduler_pkg.sv
// Shared widths, scheduling-mode constants and packet helpers for the QoS scheduler.
// Used by the drop FIFO, the bus interface and the scheduler top.
package qos_pkg;

   localparam int MODE_STRICT = 0;
   localparam int MODE_WOQ    = 1;

   // qid 0 weight sits in the LSBs: q0=1, q1=2, q2=3, q3=4
   localparam logic [31:0] DEFAULT_QWEIGHT = {8'd4, 8'd3, 8'd2, 8'd1};

   typedef struct packed {
      logic [1:0] qid;
      logic [1:0] payload;
   } pkt_t;

   function automatic int qid_width(input int num_q);
      return (num_q > 1) ? $clog2(num_q) : 1;
   endfunction

   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic logic [31:0] pkt_pack(input int unsigned qid, input int unsigned payload,
                                            input int data_w);
      return (32'(qid) << data_w) | 32'(payload);
   endfunction

endpackage

// File: rtl/qos_weighted_scheduler_if.sv
// Packet-in / packet-out bus of the QoS scheduler, including occupancy and statistics.
interface qos_weighted_scheduler_if #(
   parameter int NUM_Q  = 4,
   parameter int DEPTH  = 6,
   parameter int DATA_W = 2,
   parameter int CNT_W  = 10
);
   import qos_pkg::*;

   localparam int QID_W = qid_width(NUM_Q);
   localparam int OCC_W = occ_width(DEPTH);
   localparam int PKT_W = QID_W + DATA_W;

   logic                   in_valid;
   logic [PKT_W-1:0]       in_pkt;
   logic                   rd_req;
   logic                   out_valid;
   logic [PKT_W-1:0]       out_pkt;
   logic                   rd_empty;
   logic [NUM_Q*OCC_W-1:0] occ;
   logic [CNT_W-1:0]       ct_received;
   logic [CNT_W-1:0]       ct_transmitted;
   logic [CNT_W-1:0]       ct_dropped;

   modport master (
      output in_valid, in_pkt, rd_req,
      input  out_valid, out_pkt, rd_empty, occ, ct_received, ct_transmitted, ct_dropped
   );

   modport slave (
      input  in_valid, in_pkt, rd_req,
      output out_valid, out_pkt, rd_empty, occ, ct_received, ct_transmitted, ct_dropped
   );

endinterface

// File: rtl/qos_weighted_scheduler_drop_fifo.sv
// Circular per-queue buffer: a push into a full buffer overwrites the oldest entry
// (drop pulse), unless a pop of the same buffer happens in that cycle.
module qos_drop_fifo
   import qos_pkg::*;
#(
   parameter int DEPTH  = 6,
   parameter int DATA_W = 2,
   localparam int OCC_W = occ_width(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic [OCC_W-1:0]  occ,
   output logic              drop
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic              full;
   logic              do_pop;

   // DEPTH need not be a power of two, so wrap by explicit compare
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      full   = (occ_q == OCC_W'(DEPTH));
      do_pop = pop && (occ_q != '0);
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      drop   = 1'b0;
      if (push) begin
         tail_d = ptr_inc(tail_q);
      end
      if (do_pop) begin
         head_d = ptr_inc(head_q);
      end
      // When full, tail equals head, so the new entry overwrites the oldest one
      if (push && !do_pop) begin
         if (full) begin
            head_d = ptr_inc(head_q);
            drop   = 1'b1;
         end else begin
            occ_d = occ_q + OCC_W'(1);
         end
      end else if (do_pop && !push) begin
         occ_d = occ_q - OCC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[tail_q] <= push_data;
      end
   end

   assign head = mem_q[head_q];
   assign occ  = occ_q;

endmodule

// File: rtl/qos_weighted_scheduler.sv
// N-queue QoS buffer: per-queue drop-oldest FIFOs, strict-priority or weighted-occupancy
// read arbitration, a registered read port and saturating rx/tx/drop statistics.
module qos_weighted_scheduler
   import qos_pkg::*;
#(
   parameter int               NUM_Q   = 4,
   parameter int               DEPTH   = 6,
   parameter int               DATA_W  = 2,
   parameter int               CNT_W   = 10,
   parameter int               MODE    = MODE_WOQ,
   parameter logic [NUM_Q*8-1:0] QWEIGHT = DEFAULT_QWEIGHT
) (
   input logic                     clk,
   input logic                     reset,
   qos_weighted_scheduler_if.slave bus
);

   localparam int QID_W   = qid_width(NUM_Q);
   localparam int OCC_W   = occ_width(DEPTH);
   localparam int PKT_W   = QID_W + DATA_W;
   localparam int SCORE_W = OCC_W + 8;

   logic [QID_W-1:0]       in_qid;
   logic [DATA_W-1:0]      in_payload;
   logic [NUM_Q-1:0]       push_vec;
   logic [NUM_Q-1:0]       pop_vec;
   logic [NUM_Q-1:0]       drop_vec;
   logic [DATA_W-1:0]      head_arr [NUM_Q];
   logic [OCC_W-1:0]       occ_arr  [NUM_Q];
   logic [NUM_Q*OCC_W-1:0] occ_flat;

   logic                   any_nonempty;
   logic [QID_W-1:0]       sel_qid;
   logic [SCORE_W-1:0]     score;
   logic [SCORE_W-1:0]     best_score;

   logic                   out_valid_q, out_valid_d;
   logic                   rd_empty_q, rd_empty_d;
   logic [PKT_W-1:0]       out_pkt_q, out_pkt_d;
   logic [CNT_W-1:0]       rx_q, rx_d;
   logic [CNT_W-1:0]       tx_q, tx_d;
   logic [CNT_W-1:0]       drop_q, drop_d;

   assign in_qid     = bus.in_pkt[PKT_W-1 -: QID_W];
   assign in_payload = bus.in_pkt[DATA_W-1:0];

   for (genvar g = 0; g < NUM_Q; g++) begin : g_queue
      qos_drop_fifo #(
         .DEPTH  (DEPTH),
         .DATA_W (DATA_W)
      ) u_fifo (
         .clk       (clk),
         .reset     (reset),
         .push      (push_vec[g]),
         .push_data (in_payload),
         .pop       (pop_vec[g]),
         .head      (head_arr[g]),
         .occ       (occ_arr[g]),
         .drop      (drop_vec[g])
      );
   end

   // Arbiter sees registered occupancy only, so a same-cycle push is never selectable
   always_comb begin
      any_nonempty = 1'b0;
      sel_qid      = '0;
      score        = '0;
      best_score   = '0;
      for (int q = 0; q < NUM_Q; q++) begin
         score = SCORE_W'(occ_arr[q]) * SCORE_W'(QWEIGHT[q*8 +: 8]);
         if (occ_arr[q] != '0) begin
            if (MODE == MODE_STRICT) begin
               sel_qid = QID_W'(q);
            end else if (!any_nonempty || (score >= best_score)) begin
               sel_qid    = QID_W'(q);
               best_score = score;
            end
            any_nonempty = 1'b1;
         end
      end
   end

   always_comb begin
      push_vec = '0;
      pop_vec  = '0;
      occ_flat = '0;
      for (int q = 0; q < NUM_Q; q++) begin
         push_vec[q] = bus.in_valid && (in_qid == QID_W'(q));
         pop_vec[q]  = bus.rd_req && any_nonempty && (sel_qid == QID_W'(q));
         occ_flat[q*OCC_W +: OCC_W] = occ_arr[q];
      end
   end

   // Counters hold at all-ones instead of wrapping
   always_comb begin
      out_valid_d = 1'b0;
      rd_empty_d  = 1'b0;
      out_pkt_d   = out_pkt_q;
      rx_d        = rx_q;
      tx_d        = tx_q;
      drop_d      = drop_q;
      if (bus.rd_req) begin
         if (any_nonempty) begin
            out_valid_d = 1'b1;
            out_pkt_d   = PKT_W'(pkt_pack(32'(sel_qid), 32'(head_arr[sel_qid]), DATA_W));
            if (tx_q != '1) begin
               tx_d = tx_q + CNT_W'(1);
            end
         end else begin
            rd_empty_d = 1'b1;
         end
      end
      if (bus.in_valid && (rx_q != '1)) begin
         rx_d = rx_q + CNT_W'(1);
      end
      if ((drop_vec != '0) && (drop_q != '1)) begin
         drop_d = drop_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q <= 1'b0;
         rd_empty_q  <= 1'b0;
         out_pkt_q   <= '0;
         rx_q        <= '0;
         tx_q        <= '0;
         drop_q      <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         rd_empty_q  <= rd_empty_d;
         out_pkt_q   <= out_pkt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         drop_q      <= drop_d;
      end
   end

   assign bus.out_valid      = out_valid_q;
   assign bus.rd_empty       = rd_empty_q;
   assign bus.out_pkt        = out_pkt_q;
   assign bus.occ            = occ_flat;
   assign bus.ct_received    = rx_q;
   assign bus.ct_transmitted = tx_q;
   assign bus.ct_dropped     = drop_q;

endmodule
